capture_seq: RTL

- Sequencer for the 1-bit capture/dump path: arms, optionally waits for a trigger, then packs the serial sample bit `sig` into WORD_W-bit words.
- Fills a 2^AW-word block RAM (SB_RAM40_4K-style: registered write, 1-cycle synchronous read), then reads the RAM back and streams every word to the UART transmitter, high byte first, using its tx_start/tx_busy handshake.
- Replaces the free-running capture and manual `next` readout with a single self-sequenced capture-and-dump transaction.

---
 rtl/capture_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/capture_seq.sv
// Capture/dump sequencer: arms, optionally waits for a trigger edge, packs serial
// samples into RAM words, then streams the RAM to the UART high byte first.
module capture_seq #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic              trig,
  input  logic              sig,
  output logic [AW-1:0]     ram_waddr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_raddr,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [7:0]        tx_dat,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BCNT_W = $clog2(WORD_W);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
  localparam logic [AW-1:0]     ADDR_LAST = {AW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO
  } state_e;

  state_e              state_q, state_d;
  logic                trig_dly_q;
  // Only the WORD_W-1 older samples are stored; the newest comes straight from sig.
  logic [WORD_W-2:0]   sh_q, sh_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                first_q, first_d;
  logic                ram_we_q, ram_we_d;
  logic [AW-1:0]       ram_waddr_q, ram_waddr_d;
  logic [WORD_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [7:0]          tx_dat_q, tx_dat_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                trig_rise;

  assign trig_rise = trig & ~trig_dly_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_dly_q  <= 1'b0;
      sh_q        <= '0;
      bcnt_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      word_q      <= '0;
      first_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      tx_dat_q    <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_dly_q  <= trig;
      sh_q        <= sh_d;
      bcnt_q      <= bcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      word_q      <= word_d;
      first_q     <= first_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      tx_dat_q    <= tx_dat_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bcnt_d      = bcnt_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    word_d      = word_q;
    first_d     = 1'b0;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    tx_dat_d    = tx_dat_q;
    tx_start_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          wptr_d  = '0;
          bcnt_d  = '0;
          rptr_d  = '0;
          state_d = trig_mode ? S_ARMED : S_CAPTURE;
        end
      end
      S_ARMED: begin
        if (trig_rise) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        sh_d   = {sh_q[WORD_W-3:0], sig};
        bcnt_d = BCNT_W'(bcnt_q + 1'b1);
        if (bcnt_q == BCNT_LAST) begin
          bcnt_d      = '0;
          ram_we_d    = 1'b1;
          ram_waddr_d = wptr_q;
          ram_wdata_d = {sh_q, sig};
          if (wptr_q == ADDR_LAST) begin
            state_d = S_RD_ADDR;
          end else begin
            wptr_d = AW'(wptr_q + 1'b1);
          end
        end
      end
      S_RD_ADDR: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        word_d  = ram_rdata;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (!tx_busy) begin
          tx_dat_d   = word_q[WORD_W-1 -: 8];
          tx_start_d = 1'b1;
          first_d    = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // The UART raises tx_busy one cycle after the strobe, so skip that cycle.
        if (!first_q && !tx_busy) begin
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (!tx_busy) begin
          tx_dat_d   = word_q[7:0];
          tx_start_d = 1'b1;
          first_d    = 1'b1;
          state_d    = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!first_q && !tx_busy) begin
          if (rptr_q == ADDR_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rptr_d  = AW'(rptr_q + 1'b1);
            state_d = S_RD_ADDR;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort cancels any pending write/strobe and leaves tx_dat untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      ram_we_d   = 1'b0;
      tx_start_d = 1'b0;
      tx_dat_d   = tx_dat_q;
      done_d     = 1'b0;
      first_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_raddr = rptr_q;
  assign tx_dat    = tx_dat_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
